// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - FU result request and writeback bus bundle for wb_arbiter
interface wb_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_rw_en;
  logic [NREQ*REG_W-1:0]  req_rd;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   wb_valid;
  logic                   wb_ready;
  logic                   wb_rw_en;
  logic [REG_W-1:0]       wb_rd;
  logic [DATA_W-1:0]      wb_data;
  logic [NREQ-1:0]        wb_src;
  logic [NREQ-1:0]        done;

  modport slave (
    input  req_valid, req_rw_en, req_rd, req_data, wb_ready,
    output req_ready, wb_valid, wb_rw_en, wb_rd, wb_data, wb_src, done
  );

  modport master (
    output req_valid, req_rw_en, req_rd, req_data, wb_ready,
    input  req_ready, wb_valid, wb_rw_en, wb_rd, wb_data, wb_src, done
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter with 1-entry holding slot per FU
module wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic        CLK,
  input  logic        nRST,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   hold_valid;
  logic [NREQ-1:0]   hold_rw_en;
  logic [REG_W-1:0]  hold_rd   [NREQ];
  logic [DATA_W-1:0] hold_data [NREQ];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  lock_idx;
  logic              lock;

  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   cap;
  logic [NREQ-1:0]   done_v;
  logic              wb_valid_v;
  logic              fire;

  // Lock pins the grant while stalled so the presented entry cannot change under backpressure.
  always_comb begin : arbitrate
    logic [PTR_W:0] cand;
    logic           found;
    cand      = '0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) cand = cand - (PTR_W+1)'(NREQ);
      if (!found && hold_valid[cand[PTR_W-1:0]]) begin
        grant_idx = cand[PTR_W-1:0];
        found     = 1'b1;
      end
    end
    if (lock) grant_idx = lock_idx;
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) grant[i] = (grant_idx == PTR_W'(i));
  end

  assign next_ptr   = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + PTR_W'(1);
  assign wb_valid_v = ~nRST & (|hold_valid);
  assign fire       = wb_valid_v & bus.wb_ready;
  assign done_v     = fire ? grant : '0;
  assign cap        = bus.req_valid & bus.req_ready;

  // A slot drained this cycle may refill in the same cycle, hence the wb_ready term.
  assign bus.req_ready = nRST ? '0 : (~hold_valid | done_v);
  assign bus.wb_valid  = wb_valid_v;
  assign bus.wb_src    = wb_valid_v ? grant : '0;
  assign bus.done      = done_v;

  always_comb begin
    bus.wb_rw_en = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        bus.wb_rw_en = hold_rw_en[i];
        bus.wb_rd    = hold_rd[i];
        bus.wb_data  = hold_data[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      lock       <= 1'b0;
      lock_idx   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cap[i])         hold_valid[i] <= 1'b1;
        else if (done_v[i]) hold_valid[i] <= 1'b0;
      end
      if (fire) begin
        rr_ptr <= next_ptr;
        lock   <= 1'b0;
      end else if (wb_valid_v) begin
        lock     <= 1'b1;
        lock_idx <= grant_idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (cap[i]) begin
        hold_rw_en[i] <= bus.req_rw_en[i];
        hold_rd[i]    <= bus.req_rd[i*REG_W +: REG_W];
        hold_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  localparam int NREQ   = 3;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .REG_W(REG_W)) bus();

  wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .CLK  (clk),
    .nRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic rw, input logic [REG_W-1:0] rd,
                         input logic [DATA_W-1:0] data);
    bus.req_valid[i]                = 1'b1;
    bus.req_rw_en[i]                = rw;
    bus.req_rd[i*REG_W +: REG_W]    = rd;
    bus.req_data[i*DATA_W +: DATA_W] = data;
  endtask

  task automatic idle_req();
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_rw_en = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.wb_ready  = 1'b1;
    @(negedge clk);
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b expected 000", bus.req_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.wb_src !== 3'b000) begin errors++; $display("FAIL reset_wb_src: got %b expected 000", bus.wb_src); end
    checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b expected 000", bus.done); end
    @(negedge clk);
    rst = 1'b0;
    idle_req();
    #1;
    checks++; if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL post_reset_req_ready: got %b expected 111", bus.req_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL post_reset_wb_valid: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_single_alu();
    @(negedge clk);
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    bus.wb_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready[0] !== 1'b1) begin errors++; $display("FAIL single_req_ready: got %b expected 1", bus.req_ready[0]); end
    @(negedge clk);
    idle_req();
    #1;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b expected 1", bus.wb_valid); end
    checks++; if (bus.wb_src !== 3'b001) begin errors++; $display("FAIL single_wb_src: got %b expected 001", bus.wb_src); end
    checks++; if (bus.wb_rd !== 5'd5) begin errors++; $display("FAIL single_wb_rd: got %0d expected 5", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wb_data: got %h expected deadbeef", bus.wb_data); end
    checks++; if (bus.wb_rw_en !== 1'b1) begin errors++; $display("FAIL single_wb_rw_en: got %b expected 1", bus.wb_rw_en); end
    checks++; if (bus.done !== 3'b001) begin errors++; $display("FAIL single_done: got %b expected 001", bus.done); end
    // rr_ptr is now 1, so BRANCH must beat ALU when both are captured together.
    @(negedge clk);
    set_req(0, 1'b1, 5'd1, 32'h0000_000A);
    set_req(2, 1'b1, 5'd2, 32'h0000_000C);
    #1;
    checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL single_done_once: got %b expected 000", bus.done); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", bus.wb_valid); end
    @(negedge clk);
    idle_req();
    #1;
    checks++; if (bus.wb_src !== 3'b100) begin errors++; $display("FAIL rrptr1_first_src: got %b expected 100", bus.wb_src); end
    checks++; if (bus.wb_data !== 32'h0000_000C) begin errors++; $display("FAIL rrptr1_first_data: got %h expected 0000000c", bus.wb_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_src !== 3'b001) begin errors++; $display("FAIL rrptr1_second_src: got %b expected 001", bus.wb_src); end
    checks++; if (bus.wb_data !== 32'h0000_000A) begin errors++; $display("FAIL rrptr1_second_data: got %h expected 0000000a", bus.wb_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rrptr1_idle: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_src;
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h0000_0100);
    set_req(1, 1'b1, 5'd2, 32'h0000_0200);
    set_req(2, 1'b1, 5'd3, 32'h0000_0300);
    bus.wb_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL rr_req_ready: got %b expected 111", bus.req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_req();
      #1;
      exp_src = 3'b001 << k;
      checks++; if (bus.wb_src !== exp_src) begin errors++; $display("FAIL rr_src_%0d: got %b expected %b", k, bus.wb_src, exp_src); end
      checks++; if (bus.done !== exp_src) begin errors++; $display("FAIL rr_done_%0d: got %b expected %b", k, bus.done, exp_src); end
      checks++; if (bus.wb_data !== 32'((k + 1) << 8)) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", k, bus.wb_data, 32'((k + 1) << 8)); end
      checks++; if (bus.wb_rd !== 5'(k + 1)) begin errors++; $display("FAIL rr_rd_%0d: got %0d expected %0d", k, bus.wb_rd, k + 1); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_req(1, 1'b1, 5'd7, 32'hAAAA_5555);
    bus.wb_ready = 1'b0;
    #1;
    @(negedge clk);
    idle_req();
    set_req(0, 1'b1, 5'd9, 32'h0000_1234);
    #1;
    checks++; if (bus.wb_src !== 3'b010) begin errors++; $display("FAIL bp_src_1: got %b expected 010", bus.wb_src); end
    checks++; if (bus.wb_data !== 32'hAAAA_5555) begin errors++; $display("FAIL bp_data_1: got %h expected aaaa5555", bus.wb_data); end
    checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL bp_done_1: got %b expected 000", bus.done); end
    checks++; if (bus.req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_alu_ready_1: got %b expected 1", bus.req_ready[0]); end
    for (int s = 2; s <= 4; s++) begin
      @(negedge clk);
      idle_req();
      set_req(0, 1'b1, 5'd3, 32'h0000_0BAD);
      #1;
      checks++; if (bus.wb_src !== 3'b010) begin errors++; $display("FAIL bp_src_%0d: got %b expected 010", s, bus.wb_src); end
      checks++; if (bus.wb_data !== 32'hAAAA_5555) begin errors++; $display("FAIL bp_data_%0d: got %h expected aaaa5555", s, bus.wb_data); end
      checks++; if (bus.wb_rd !== 5'd7) begin errors++; $display("FAIL bp_rd_%0d: got %0d expected 7", s, bus.wb_rd); end
      checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL bp_done_%0d: got %b expected 000", s, bus.done); end
      checks++; if (bus.req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_alu_full_%0d: got %b expected 0", s, bus.req_ready[0]); end
    end
    @(negedge clk);
    idle_req();
    bus.wb_ready = 1'b1;
    #1;
    checks++; if (bus.wb_src !== 3'b010) begin errors++; $display("FAIL bp_release_src: got %b expected 010", bus.wb_src); end
    checks++; if (bus.done !== 3'b010) begin errors++; $display("FAIL bp_release_done: got %b expected 010", bus.done); end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_src !== 3'b001) begin errors++; $display("FAIL bp_alu_src: got %b expected 001", bus.wb_src); end
    checks++; if (bus.wb_data !== 32'h0000_1234) begin errors++; $display("FAIL bp_alu_data: got %h expected 00001234", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd9) begin errors++; $display("FAIL bp_alu_rd: got %0d expected 9", bus.wb_rd); end
    checks++; if (bus.done !== 3'b001) begin errors++; $display("FAIL bp_alu_done: got %b expected 001", bus.done); end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d [4];
    d[0] = 32'h0000_0011;
    d[1] = 32'h0000_0022;
    d[2] = 32'h0000_0033;
    d[3] = 32'h0000_0044;
    bus.wb_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) set_req(0, 1'b1, 5'(k + 1), d[k]);
      else idle_req();
      #1;
      checks++; if (bus.req_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", k, bus.req_ready[0]); end
      if (k == 0) begin
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_idle: got %b expected 0", bus.wb_valid); end
      end else begin
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d: got %b expected 1", k, bus.wb_valid); end
        checks++; if (bus.wb_data !== d[k-1]) begin errors++; $display("FAIL b2b_data_%0d: got %h expected %h", k, bus.wb_data, d[k-1]); end
        checks++; if (bus.done !== 3'b001) begin errors++; $display("FAIL b2b_done_%0d: got %b expected 001", k, bus.done); end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_req(1, 1'b1, 5'd4, 32'h0000_0044);
    set_req(2, 1'b1, 5'd6, 32'h0000_0066);
    bus.wb_ready = 1'b0;
    #1;
    @(negedge clk);
    idle_req();
    rst = 1'b1;
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL mid_rst_req_ready: got %b expected 000", bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 5'd8, 32'h0000_0088);
    set_req(1, 1'b1, 5'd10, 32'h0000_00A0);
    bus.wb_ready = 1'b1;
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mid_after_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.done !== 3'b000) begin errors++; $display("FAIL mid_after_done: got %b expected 000", bus.done); end
    checks++; if (bus.req_ready !== 3'b111) begin errors++; $display("FAIL mid_after_req_ready: got %b expected 111", bus.req_ready); end
    @(negedge clk);
    idle_req();
    #1;
    checks++; if (bus.wb_src !== 3'b001) begin errors++; $display("FAIL mid_alu_wins_src: got %b expected 001", bus.wb_src); end
    checks++; if (bus.wb_data !== 32'h0000_0088) begin errors++; $display("FAIL mid_alu_wins_data: got %h expected 00000088", bus.wb_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_src !== 3'b010) begin errors++; $display("FAIL mid_ldst_src: got %b expected 010", bus.wb_src); end
    checks++; if (bus.wb_data !== 32'h0000_00A0) begin errors++; $display("FAIL mid_ldst_data: got %h expected 000000a0", bus.wb_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_completion_only();
    @(negedge clk);
    set_req(2, 1'b0, 5'd0, 32'h0000_CAFE);
    bus.wb_ready = 1'b1;
    #1;
    @(negedge clk);
    idle_req();
    #1;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL co_wb_valid: got %b expected 1", bus.wb_valid); end
    checks++; if (bus.wb_rw_en !== 1'b0) begin errors++; $display("FAIL co_wb_rw_en: got %b expected 0", bus.wb_rw_en); end
    checks++; if (bus.wb_src !== 3'b100) begin errors++; $display("FAIL co_wb_src: got %b expected 100", bus.wb_src); end
    checks++; if (bus.done !== 3'b100) begin errors++; $display("FAIL co_done: got %b expected 100", bus.done); end
    @(negedge clk);
    set_req(0, 1'b1, 5'd0, 32'h0000_5A5A);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL co_idle: got %b expected 0", bus.wb_valid); end
    @(negedge clk);
    idle_req();
    #1;
    checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL x0_wb_rd: got %0d expected 0", bus.wb_rd); end
    checks++; if (bus.wb_rw_en !== 1'b1) begin errors++; $display("FAIL x0_wb_rw_en: got %b expected 1", bus.wb_rw_en); end
    checks++; if (bus.wb_data !== 32'h0000_5A5A) begin errors++; $display("FAIL x0_wb_data: got %h expected 00005a5a", bus.wb_data); end
    @(negedge clk);
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL x0_idle: got %b expected 0", bus.wb_valid); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_completion_only();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
